inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction/immediate decode logic.
- Maintains the fetch PC and issues single-word reads on a classic Wishbone master port.
- Presents each fetched instruction word, with its PC, on a valid/ready output to decode.
- Accepts redirects (branch/jump/trap) from execute; a redirect flushes any held or in-flight instruction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset release; bits [1:0] must be 0.
NOP_INST, 32'h0000_0013, value driven on inst while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe, always equal to wb_cyc_o
wb_adr_o  output  30  word address, equal to pc[31:2]
wb_dat_i  input  32  read data
wb_ack_i  input  1  read acknowledge
redirect_valid  input  1  single-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0
inst_valid  output  1  inst/inst_pc hold a valid instruction
inst_ready  input  1  decode accepts the instruction this cycle
inst  output  32  instruction word to decode
inst_pc  output  32  address of inst, with bits [1:0] = 0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC; state = IDLE.
  - wb_cyc_o = wb_stb_o = 0; inst_valid = 0.
  - inst = NOP_INST; inst_pc = RESET_PC.
- Reset asserted mid-transaction: the bus cycle is abandoned, with cyc dropped asynchronously. No data is delivered.
- Output slot: a single register (inst, inst_pc, inst_valid).
  - A transfer occurs when inst_valid && inst_ready.
  - Without a transfer, the slot contents hold stable.
- Only one bus request is ever outstanding. wb_cyc_o and wb_stb_o are held high until wb_ack_i.
- State IDLE (cyc = 0):
  - Go to BUS when (!inst_valid || inst_ready) && !redirect_valid.
- State BUS (cyc = stb = 1, adr = pc[31:2]):
  - On wb_ack_i without redirect: capture inst <= wb_dat_i, inst_pc <= pc, inst_valid <= 1; pc <= pc + 4 (wraps modulo 2^32); go to IDLE.
  - The slot is guaranteed empty at ack, because a request is only issued when the slot is free or being freed.
- State DRAIN (cyc = stb = 1, adr = previous address held): the stale request is awaiting ack.
  - On ack: discard data, do not change pc, go to IDLE.
- Redirect has priority over ack capture and over output transfer:
  - Always: pc <= {redirect_pc[31:2], 2'b00}; inst_valid <= 0; inst <= NOP_INST.
  - In IDLE: stay in IDLE (the fetch issues next cycle).
  - In BUS without ack: go to DRAIN; wb_adr_o stays at the old address until ack.
  - In BUS with ack the same cycle: data is discarded; go to IDLE.
  - In DRAIN without ack: stay in DRAIN, with pc updated to the newest redirect.
  - In DRAIN with ack: go to IDLE.
  - An output transfer in the same cycle as a redirect is still counted as accepted by decode. Execute is responsible for ignoring it.
- Timing:
  - First wb_cyc_o is high in the first clock after reset_n deasserts.
  - With a zero-wait slave (ack in the first stb cycle), inst_valid rises the cycle after ack.
  - Maximum throughput is 1 instruction per 2 cycles.
- inst_valid never deasserts without a transfer, except on redirect.
- inst and inst_pc never change while inst_valid && !inst_ready, except on redirect.
- wb_adr_o is registered; it changes only when entering BUS.

Test Plan:
- Reset then zero-wait slave returning word=addr, inst_ready=1 → fetches 0x0,0x4,0x8 with inst_pc matching and inst_valid every 2nd cycle; first cyc in 1st cycle after reset release.
- Stall: inst_ready=0 after first word → inst=0x00000000 and inst_pc=0 held stable; no new cyc issued; on ready=1, next fetch 0x4 starts that cycle.
- Redirect to 0x100 while BUS waiting 3 cycles for ack → DRAIN, adr stays old; ack data dropped; next request adr=0x40 (word), inst_pc=0x100.
- Redirect coinciding with ack, and redirect_pc=0x203 → data dropped, inst_valid=0 next cycle, next fetch at 0x200.
- PC wrap: RESET_PC=0xFFFF_FFFC → fetch 0xFFFF_FFFC then 0x0000_0000.
- Assert reset_n=0 mid-BUS → cyc/stb/inst_valid low immediately, inst=0x00000013; refetch RESET_PC after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the fetch PC, reads one word at a time over Wishbone and
// hands each word with its PC to decode through a single valid/ready output register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [29:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {StIdle, StBus, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        adr_d     = adr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;

        if (valid_q && inst_ready) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        unique case (state_q)
            StIdle: begin
                if ((!valid_q || inst_ready) && !redirect_valid) begin
                    state_d = StBus;
                    adr_d   = pc_q[31:2];
                end
            end
            StBus: begin
                if (wb_ack_i) begin
                    state_d = StIdle;
                    // The slot is always empty here, so capture never collides with a held word.
                    if (!redirect_valid) begin
                        inst_d    = wb_dat_i;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wb_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides capture and transfer; an in-flight request drains to completion.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            adr_q     <= RESET_PC[31:2];
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            adr_q     <= adr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign wb_cyc_o   = (state_q != StIdle);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_adr_o   = adr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: simple Wishbone slave returning word = byte address,
// with programmable ack latency, plus a second instance checking PC wrap-around.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        rst2_n;
    logic        cyc2, stb2, valid2;
    logic [29:0] adr2;
    logic [31:0] inst2, inst_pc2;

    int          lat;
    int          cnt;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    // Slave: ack after 'lat' wait cycles of an active strobe.
    assign wb_ack_i = wb_cyc_o && wb_stb_o && (cnt == lat);
    assign wb_dat_i = {wb_adr_o, 2'b00};
    always @(posedge clk) cnt <= (wb_cyc_o && !wb_ack_i) ? cnt + 1 : 0;

    inst_fetch u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .reset_n        (rst2_n),
        .wb_cyc_o       (cyc2),
        .wb_stb_o       (stb2),
        .wb_adr_o       (adr2),
        .wb_dat_i       ({adr2, 2'b00}),
        .wb_ack_i       (cyc2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (valid2),
        .inst_ready     (1'b1),
        .inst           (inst2),
        .inst_pc        (inst_pc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        rst2_n         = 1'b0;
        cnt            = 0;
        lat            = 0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        check("rst_cyc", {31'h0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'h0, wb_stb_o}, 32'd0);
        check("rst_valid", {31'h0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_wrap_pc", inst_pc2, 32'hFFFF_FFFC);
        step();
        reset_n = 1'b1;

        // First fetch: cyc in first cycle after release, zero-wait ack.
        step();
        check("f0_cyc", {31'h0, wb_cyc_o}, 32'd1);
        check("f0_adr", {2'b0, wb_adr_o}, 32'h0);
        step();
        check("f0_valid", {31'h0, inst_valid}, 32'd1);
        check("f0_inst", inst, 32'h0);
        check("f0_pc", inst_pc, 32'h0);
        check("f0_cyc_idle", {31'h0, wb_cyc_o}, 32'd0);

        // Stall with the first word held.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'h0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'h0);
            check("stall_pc", inst_pc, 32'h0);
            check("stall_cyc", {31'h0, wb_cyc_o}, 32'd0);
        end
        inst_ready = 1'b1;

        // Back-to-back fetches of 0x4, 0x8: one instruction every two cycles.
        for (int k = 1; k < 3; k++) begin
            step();
            check("seq_cyc", {31'h0, wb_cyc_o}, 32'd1);
            check("seq_adr", {2'b0, wb_adr_o}, k);
            check("seq_valid_lo", {31'h0, inst_valid}, 32'd0);
            step();
            check("seq_valid", {31'h0, inst_valid}, 32'd1);
            check("seq_inst", inst, 4 * k);
            check("seq_pc", inst_pc, 4 * k);
        end

        // Redirect to 0x100 while a slow request (3 waits) is outstanding.
        lat = 3;
        step();
        check("rd_cyc", {31'h0, wb_cyc_o}, 32'd1);
        check("rd_adr", {2'b0, wb_adr_o}, 32'h3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("drain_cyc", {31'h0, wb_cyc_o}, 32'd1);
        check("drain_adr", {2'b0, wb_adr_o}, 32'h3);
        step();
        check("drain_adr2", {2'b0, wb_adr_o}, 32'h3);
        step();
        check("drain_ack", {31'h0, wb_ack_i}, 32'd1);
        check("drain_adr3", {2'b0, wb_adr_o}, 32'h3);
        step();
        check("drop_cyc", {31'h0, wb_cyc_o}, 32'd0);
        check("drop_valid", {31'h0, inst_valid}, 32'd0);
        check("drop_inst", inst, 32'h0000_0013);
        step();
        check("rd_new_cyc", {31'h0, wb_cyc_o}, 32'd1);
        check("rd_new_adr", {2'b0, wb_adr_o}, 32'h40);
        lat = 0;
        step();
        check("rd_new_valid", {31'h0, inst_valid}, 32'd1);
        check("rd_new_pc", inst_pc, 32'h100);
        check("rd_new_inst", inst, 32'h100);

        // Redirect coinciding with ack, unaligned target 0x203.
        step();
        check("rc_ack", {31'h0, wb_ack_i}, 32'd1);
        check("rc_adr", {2'b0, wb_adr_o}, 32'h41);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        check("rc_valid", {31'h0, inst_valid}, 32'd0);
        check("rc_cyc", {31'h0, wb_cyc_o}, 32'd0);
        check("rc_inst", inst, 32'h0000_0013);
        step();
        check("rc_new_adr", {2'b0, wb_adr_o}, 32'h80);
        step();
        check("rc_new_valid", {31'h0, inst_valid}, 32'd1);
        check("rc_new_pc", inst_pc, 32'h200);

        // Asynchronous reset while a request is outstanding.
        lat = 5;
        step();
        check("mr_cyc", {31'h0, wb_cyc_o}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_cyc_lo", {31'h0, wb_cyc_o}, 32'd0);
        check("mr_stb_lo", {31'h0, wb_stb_o}, 32'd0);
        check("mr_valid_lo", {31'h0, inst_valid}, 32'd0);
        check("mr_inst", inst, 32'h0000_0013);
        check("mr_pc", inst_pc, 32'h0);
        step();
        reset_n = 1'b1;
        lat     = 0;
        step();
        check("mr_re_cyc", {31'h0, wb_cyc_o}, 32'd1);
        check("mr_re_adr", {2'b0, wb_adr_o}, 32'h0);
        step();
        check("mr_re_valid", {31'h0, inst_valid}, 32'd1);
        check("mr_re_pc", inst_pc, 32'h0);

        // PC wrap on the second instance.
        rst2_n = 1'b1;
        step();
        check("wrap_adr0", {2'b0, adr2}, 32'h3FFF_FFFF);
        step();
        check("wrap_pc0", inst_pc2, 32'hFFFF_FFFC);
        check("wrap_inst0", inst2, 32'hFFFF_FFFC);
        step();
        check("wrap_adr1", {2'b0, adr2}, 32'h0);
        step();
        check("wrap_valid1", {31'h0, valid2}, 32'd1);
        check("wrap_pc1", inst_pc2, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
